// File: rtl/lsu_controller.sv
// Load-store unit between the core data port and data memory: issues one memory
// transaction per core access, stalls the core until ready, and faults on bad accesses.
//
// state  | meaning
// IDLE   | no transaction open; a legal core request issues immediately
// WAIT   | transaction open, waiting for mem_ready_i or the timeout
module lsu_controller #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_fault_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [1:0]  off_q;
  logic [2:0]  size_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] wd_q;

  logic        illegal, misaligned, bad, issue;
  logic [3:0]  be_c;
  logic [31:0] wd_c;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    illegal    = (core_size_i == 3'd3) || (core_size_i >= 3'd6) ||
                 (core_we_i && (core_size_i == 3'd4 || core_size_i == 3'd5));
    misaligned = ((core_size_i == 3'd1 || core_size_i == 3'd5) && core_addr_i[0]) ||
                 ((core_size_i == 3'd2) && (core_addr_i[1:0] != 2'b00));
    bad        = core_req_i && (illegal || misaligned);
    issue      = (state == S_IDLE) && core_req_i && !bad;
  end

  // BU/HU share the low size bits with B/H, so size[1:0] selects the lane pattern.
  always_comb begin
    case (core_size_i[1:0])
      2'd0: begin
        be_c = 4'b0001 << core_addr_i[1:0];
        wd_c = {4{core_wd_i[7:0]}};
      end
      2'd1: begin
        be_c = 4'b0011 << {core_addr_i[1], 1'b0};
        wd_c = {2{core_wd_i[15:0]}};
      end
      default: begin
        be_c = 4'b1111;
        wd_c = core_wd_i;
      end
    endcase
  end

  always_comb begin
    ld_byte = 8'(mem_rd_i >> {off_q, 3'b000});
    ld_half = off_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    case (size_q)
      3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    ld_ext = {24'd0, ld_byte};
      3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
      3'd5:    ld_ext = {16'd0, ld_half};
      default: ld_ext = mem_rd_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= S_IDLE;
      cnt    <= 8'd0;
      off_q  <= 2'd0;
      size_q <= 3'd0;
      we_q   <= 1'b0;
      be_q   <= 4'd0;
      addr_q <= 32'd0;
      wd_q   <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue) begin
            state  <= S_WAIT;
            cnt    <= 8'd0;
            off_q  <= core_addr_i[1:0];
            size_q <= core_size_i;
            we_q   <= core_we_i;
            be_q   <= be_c;
            addr_q <= {core_addr_i[31:2], 2'b00};
            wd_q   <= wd_c;
          end
        end
        S_WAIT: begin
          if (mem_ready_i || cnt == CNT_LAST) state <= S_IDLE;
          else                                cnt   <= cnt + 8'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are Mealy so the issuing cycle already stalls the core and drives memory.
  always_comb begin
    core_rd_o    = 32'd0;
    core_stall_o = 1'b0;
    core_fault_o = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = 4'd0;
    mem_addr_o   = 32'd0;
    mem_wd_o     = 32'd0;
    if (!rst_i) begin
      if (state == S_IDLE) begin
        if (bad) begin
          core_fault_o = 1'b1;
        end else if (core_req_i) begin
          mem_req_o    = 1'b1;
          core_stall_o = 1'b1;
          mem_we_o     = core_we_i;
          mem_be_o     = be_c;
          mem_addr_o   = {core_addr_i[31:2], 2'b00};
          mem_wd_o     = wd_c;
        end
      end else begin
        mem_req_o  = 1'b1;
        mem_we_o   = we_q;
        mem_be_o   = be_q;
        mem_addr_o = addr_q;
        mem_wd_o   = wd_q;
        if (mem_ready_i) begin
          if (!we_q) core_rd_o = ld_ext;
        end else if (cnt == CNT_LAST) begin
          core_fault_o = 1'b1;
        end else begin
          core_stall_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_controller.sv
// Self-checking bench for lsu_controller: directed cases plus random accesses
// compared against a byte-lane arithmetic model of the access rules.
module tb_lsu_controller;
  localparam int TO = 16;

  logic        clk_i = 1'b0;
  logic        rst_i, core_req_i, core_we_i, mem_ready_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i, core_wd_i, mem_rd_i;
  logic [31:0] core_rd_o, mem_addr_o, mem_wd_o;
  logic        core_stall_o, core_fault_o, mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;

  int errors = 0;
  int checks = 0;

  lsu_controller #(.TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .core_req_i(core_req_i), .core_we_i(core_we_i),
    .core_size_i(core_size_i), .core_addr_i(core_addr_i), .core_wd_i(core_wd_i),
    .core_rd_o(core_rd_o), .core_stall_o(core_stall_o), .core_fault_o(core_fault_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i),
    .mem_ready_i(mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_bad(input bit we, input logic [2:0] sz, input logic [31:0] a);
    bit ill, mis;
    ill = !(sz inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (we && sz >= 3'd4);
    mis = ((sz == 3'd1 || sz == 3'd5) && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00);
    return ill || mis;
  endfunction

  function automatic int m_nb(input logic [2:0] sz);
    if (sz == 3'd0 || sz == 3'd4) return 1;
    if (sz == 3'd1 || sz == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] sz, input logic [31:0] a);
    logic [3:0] m;
    m = 4'((1 << m_nb(sz)) - 1);
    return m << a[1:0];
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    int nb;
    nb = m_nb(sz);
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = wd[(i % nb)*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] sz, input logic [31:0] a,
                                       input logic [31:0] word);
    logic [31:0] v, mask;
    int nb;
    nb = m_nb(sz);
    v = word >> (8 * a[1:0]);
    mask = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
    v = v & mask;
    if (sz < 3'd4 && nb < 4 && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic drive_edge();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_cycle();
    drive_edge();
    core_req_i  = 1'b0;
    mem_ready_i = 1'($urandom_range(0, 1));
    @(negedge clk_i);
    check("idle_req", 32'(mem_req_o), 32'd0);
    check("idle_stall", 32'(core_stall_o), 32'd0);
    check("idle_rd", core_rd_o, 32'd0);
  endtask

  // One core access; waits >= TO means memory never answers.
  task automatic access(input bit we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] word, input int waits,
                        output logic [31:0] got_rd, output int stall_cycles);
    logic [3:0]  be_e;
    logic [31:0] wd_e;
    got_rd = 32'd0;
    stall_cycles = 0;
    drive_edge();
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = sz;
    core_addr_i = a;
    core_wd_i   = wd;
    mem_ready_i = 1'($urandom_range(0, 1));
    mem_rd_i    = $urandom;
    @(negedge clk_i);
    if (m_bad(we, sz, a)) begin
      check("bad_fault", 32'(core_fault_o), 32'd1);
      check("bad_req", 32'(mem_req_o), 32'd0);
      check("bad_stall", 32'(core_stall_o), 32'd0);
      core_req_i = 1'b0;
      return;
    end
    be_e = m_be(sz, a);
    wd_e = m_wd(sz, wd);
    if (core_stall_o) stall_cycles++;
    check("iss_req", 32'(mem_req_o), 32'd1);
    check("iss_stall", 32'(core_stall_o), 32'd1);
    check("iss_fault", 32'(core_fault_o), 32'd0);
    check("iss_be", 32'(mem_be_o), 32'(be_e));
    check("iss_addr", mem_addr_o, a & 32'hFFFF_FFFC);
    check("iss_we", 32'(mem_we_o), 32'(we));
    if (we) check("iss_wd", mem_wd_o, wd_e);
    for (int k = 0; k < TO; k++) begin
      drive_edge();
      core_addr_i = $urandom;
      core_wd_i   = $urandom;
      mem_ready_i = (k == waits);
      mem_rd_i    = (k == waits) ? word : $urandom;
      @(negedge clk_i);
      if (core_stall_o) stall_cycles++;
      check("w_req", 32'(mem_req_o), 32'd1);
      check("w_be", 32'(mem_be_o), 32'(be_e));
      check("w_addr", mem_addr_o, a & 32'hFFFF_FFFC);
      check("w_we", 32'(mem_we_o), 32'(we));
      if (we) check("w_wd", mem_wd_o, wd_e);
      if (k == waits) begin
        got_rd = core_rd_o;
        check("done_stall", 32'(core_stall_o), 32'd0);
        check("done_fault", 32'(core_fault_o), 32'd0);
        check("done_rd", core_rd_o, we ? 32'd0 : m_rd(sz, a, word));
        break;
      end else if (k == TO - 1) begin
        check("to_fault", 32'(core_fault_o), 32'd1);
        check("to_stall", 32'(core_stall_o), 32'd0);
        check("to_rd", core_rd_o, 32'd0);
      end else begin
        check("w_stall", 32'(core_stall_o), 32'd1);
        check("w_fault", 32'(core_fault_o), 32'd0);
      end
    end
  endtask

  logic [31:0] rd;
  int          nst;
  logic [2:0]  rsz;
  logic [31:0] raddr;
  int          rwait;
  bit          rwe;

  initial begin
    rst_i = 1'b1; core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = 3'd0;
    core_addr_i = 32'd0; core_wd_i = 32'd0; mem_rd_i = 32'd0; mem_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_stall", 32'(core_stall_o), 32'd0);
    check("rst_fault", 32'(core_fault_o), 32'd0);
    check("rst_be", 32'(mem_be_o), 32'd0);
    check("rst_rd", core_rd_o, 32'd0);
    drive_edge();
    rst_i = 1'b0;

    access(1'b0, 3'd2, 32'h100, 32'd0, 32'hDEADBEEF, 0, rd, nst);
    check("lw_rd", rd, 32'hDEADBEEF);
    check("lw_stalls", 32'(nst), 32'd1);
    access(1'b0, 3'd0, 32'h103, 32'd0, 32'h80FF1234, 0, rd, nst);
    check("lb_rd", rd, 32'hFFFFFF80);
    access(1'b0, 3'd4, 32'h103, 32'd0, 32'h80FF1234, 1, rd, nst);
    check("lbu_rd", rd, 32'h00000080);
    access(1'b0, 3'd1, 32'h102, 32'd0, 32'h80FF1234, 0, rd, nst);
    check("lh_rd", rd, 32'hFFFF80FF);
    idle_cycle();
    access(1'b1, 3'd0, 32'h101, 32'h000000A5, 32'd0, 0, rd, nst);
    access(1'b1, 3'd1, 32'h102, 32'h00001234, 32'd0, 2, rd, nst);
    access(1'b0, 3'd2, 32'h102, 32'd0, 32'd0, 0, rd, nst);
    access(1'b1, 3'd1, 32'h001, 32'd0, 32'd0, 0, rd, nst);
    access(1'b1, 3'd4, 32'h100, 32'd0, 32'd0, 0, rd, nst);
    idle_cycle();
    access(1'b0, 3'd2, 32'h200, 32'd0, 32'h12345678, 3, rd, nst);
    check("lw3_stalls", 32'(nst), 32'd4);
    access(1'b0, 3'd2, 32'h300, 32'd0, 32'd0, 1000, rd, nst);
    check("to_stalls", 32'(nst), 32'd16);
    idle_cycle();
    access(1'b0, 3'd2, 32'h400, 32'd0, 32'hCAFEF00D, TO - 1, rd, nst);
    check("ready_on_last", rd, 32'hCAFEF00D);

    // reset while a load is waiting, then a late ready
    drive_edge();
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h500;
    mem_ready_i = 1'b0;
    drive_edge();
    drive_edge();
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rstw_req_during", 32'(mem_req_o), 32'd0);
    drive_edge();
    rst_i = 1'b0; core_req_i = 1'b0; mem_ready_i = 1'b1; mem_rd_i = 32'hFFFFFFFF;
    @(negedge clk_i);
    check("rstw_req", 32'(mem_req_o), 32'd0);
    check("rstw_stall", 32'(core_stall_o), 32'd0);
    check("rstw_rd", core_rd_o, 32'd0);
    check("rstw_fault", 32'(core_fault_o), 32'd0);
    access(1'b0, 3'd2, 32'h600, 32'd0, 32'h0BADF00D, 0, rd, nst);
    check("post_rst_lw", rd, 32'h0BADF00D);

    for (int n = 0; n < 150; n++) begin
      rwe   = 1'($urandom_range(0, 1));
      rsz   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                                          : 3'($urandom_range(0, 5));
      raddr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (m_nb(rsz) == 2) raddr[0] = 1'b0;
        if (m_nb(rsz) == 4) raddr[1:0] = 2'b00;
      end
      rwait = ($urandom_range(0, 15) == 0) ? TO + 5 : $urandom_range(0, 4);
      access(rwe, rsz, raddr, $urandom, $urandom, rwait, rd, nst);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    idle_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lsu_controller.md
Name: lsu_controller

Overview:
- Load-store unit that sits between riscv_core's data-memory port and the data memory.
- Sequences each core load/store into a memory transaction with a ready handshake.
- Generates the core's stall signal, byte enables, store-data replication and load-data extraction/extension.
- Detects misaligned or illegal accesses and bounds each transaction with a timeout.

Parameters:
- TIMEOUT, 16, max cycles in WAIT before the transaction is aborted with a fault (1..255).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- core_req_i  in  1  core requests a memory access
- core_we_i  in  1  1=store, 0=load
- core_size_i  in  3  0=B, 1=H, 2=W, 4=BU, 5=HU
- core_addr_i  in  32  byte address
- core_wd_i  in  32  store data, value in the low bits
- core_rd_o  out  32  load result, extended to 32 bits
- core_stall_o  out  1  holds the core PC and suppresses its register-file write
- core_fault_o  out  1  one-cycle pulse on misaligned, illegal or timed-out access
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  word-aligned address: {core_addr_i[31:2], 2'b00}
- mem_wd_o  out  32  replicated store data
- mem_rd_i  in  32  memory read word
- mem_ready_i  in  1  memory done; read data valid this cycle

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, sampled on posedge clk_i.
- Reset values: state=IDLE, timeout counter=0, latched offset/size=0.
  - Reset outputs: core_stall_o=0, core_fault_o=0, mem_req_o=0, mem_we_o=0, mem_be_o=0, core_rd_o=0.
- Legality check (combinational):
  - illegal: size in {3,6,7}, or core_we_i=1 with size 4/5.
  - misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0.
  - bad = core_req_i & (illegal | misaligned).
- FSM states: IDLE, WAIT.
- IDLE:
  - core_req_i=0: all outputs idle (0); stay IDLE.
  - core_req_i=1 and bad: mem_req_o=0, core_fault_o=1, core_stall_o=0 (instruction retires); stay IDLE.
  - core_req_i=1 and legal: mem_req_o=1, core_stall_o=1, counter cleared. Latch addr[1:0], size and we; go to WAIT.
- WAIT:
  - mem_req_o=1; mem_we_o/mem_be_o/mem_addr_o/mem_wd_o hold the same values as the issuing cycle.
  - mem_ready_i=1: core_stall_o=0, core_rd_o valid this cycle; return to IDLE.
  - mem_ready_i=0: core_stall_o=1; counter increments.
  - Counter reaches TIMEOUT-1 with no ready: core_fault_o=1, core_stall_o=0, core_rd_o=0, mem_req_o drops next cycle; return to IDLE.
- Latency: minimum one stall cycle; a zero-wait memory completes on the second cycle of the access.
- Back-to-back accesses: the IDLE cycle following completion may issue a new request.
- Byte enables:
  - B: 4'b0001 << addr[1:0]
  - H: 4'b0011 << {addr[1],1'b0}
  - W: 4'b1111
  - Loads drive the same BE pattern.
- Store data: B → {4{wd[7:0]}}, H → {2{wd[15:0]}}, W → wd.
- Load data, using the latched offset:
  - B: sign-extended byte at offset; BU: zero-extended byte.
  - H: sign-extended half at offset[1]; HU: zero-extended half.
  - W: full word.
  - core_rd_o=0 outside a completing load cycle.
- Reset mid-transaction: immediate return to IDLE; mem_req_o=0 next cycle. A late mem_ready_i is ignored.
- mem_ready_i while in IDLE: ignored.
- mem_ready_i on the timeout cycle: ready wins; the access completes normally with no fault.

Test Plan:
- LW at 0x100, memory ready after 0 wait cycles, mem_rd_i=0xDEADBEEF:
  - Cycle 1: mem_be_o=1111, stall=1.
  - Cycle 2: stall=0, core_rd_o=0xDEADBEEF.
- LB at 0x103, mem_rd_i=0x80FF1234 → core_rd_o=0xFFFFFF80. LBU same → 0x00000080. LH at 0x102 → 0xFFFF80FF.
- SB at 0x101, wd=0x000000A5 → mem_be_o=0010, mem_wd_o=0xA5A5A5A5, mem_addr_o=0x100. SH at 0x102, wd=0x1234 → be=1100, wd=0x12341234.
- LW at 0x102; SH at 0x001; store with size=4 → each: core_fault_o pulse, mem_req_o never asserted, stall=0.
- LW with mem_ready_i=1 after 3 waits → stall high for 4 cycles, mem outputs stable throughout.
  - mem_ready_i never asserted, TIMEOUT=16 → fault on the 16th WAIT cycle, then IDLE.
- rst_i asserted in WAIT → next cycle mem_req_o=0, stall=0; a subsequent mem_ready_i is ignored and the next LW completes normally.
